// File: rtl/max_net_pkg.sv
// Shared constants for the max_net batch loader and its helpers: word format,
// loader FSM encoding and result status codes.
package max_net_pkg;
  localparam int WORD_W = 32;
  localparam int N_IN   = 4;

  localparam logic [WORD_W-1:0] FP32_EXP_MASK = 32'h7F80_0000;
  localparam logic [WORD_W-1:0] FP32_MAN_MASK = 32'h007F_FFFF;

  localparam logic [2:0] S_LOAD   = 3'd0;
  localparam logic [2:0] S_ARM    = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_RESULT = 3'd4;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_BADHOT  = 2'b01;
  localparam logic [1:0] ST_NAN     = 2'b10;
  localparam logic [1:0] ST_TIMEOUT = 2'b11;

  // NaN: all-ones exponent with a non-zero mantissa (infinities are not NaN).
  function automatic logic is_nan(input logic [WORD_W-1:0] w);
    return ((w & FP32_EXP_MASK) == FP32_EXP_MASK) && ((w & FP32_MAN_MASK) != '0);
  endfunction
endpackage

// File: rtl/mn_onehot_enc.sv
// One-hot to index encoder for max_net winners; the index is the lowest set
// bit (0 for an all-zero input) and bad flags anything that is not one-hot.
module mn_onehot_enc (
  input  logic [3:0] onehot,
  output logic [1:0] index,
  output logic       bad
);
  always_comb begin
    index = 2'd0;
    if (onehot[0])      index = 2'd0;
    else if (onehot[1]) index = 2'd1;
    else if (onehot[2]) index = 2'd2;
    else if (onehot[3]) index = 2'd3;
    bad = ($countones(onehot) != 1);
  end
endmodule

// File: rtl/max_net_loader.sv
// Batch sequencer in front of max_net: packs four FP32 words into the operand
// registers, pulses start once, waits for done (with timeout) and returns a result.
module max_net_loader
  import max_net_pkg::*;
#(
  parameter int TIMEOUT      = 1024,
  parameter bit SANITIZE_NAN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic [WORD_W-1:0] x_init_1,
  output logic [WORD_W-1:0] x_init_2,
  output logic [WORD_W-1:0] x_init_3,
  output logic [WORD_W-1:0] x_init_4,
  output logic              mn_start,
  input  logic              mn_done,
  input  logic [3:0]        mn_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [3:0]        res_winner,
  output logic [1:0]        res_index,
  output logic [1:0]        res_status,
  output logic [2:0]        fsm_state
);
  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; valid, once raised, holds its payload stable until that edge.

  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);
  localparam logic [1:0]  CNT_LAST = 2'(N_IN - 1);

  logic [2:0]        state;
  logic [1:0]        cnt;
  logic [15:0]       tcnt;
  logic              nan_flag;
  logic              nan_in;
  logic [WORD_W-1:0] word;
  logic [1:0]        enc_index;
  logic              enc_bad;

  mn_onehot_enc u_enc (
    .onehot (mn_out),
    .index  (enc_index),
    .bad    (enc_bad)
  );

  assign nan_in    = SANITIZE_NAN && is_nan(in_data);
  assign word      = nan_in ? '0 : in_data;
  assign in_ready  = (state == S_LOAD) && !rst;
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_LOAD;
      cnt        <= '0;
      tcnt       <= '0;
      nan_flag   <= 1'b0;
      x_init_1   <= '0;
      x_init_2   <= '0;
      x_init_3   <= '0;
      x_init_4   <= '0;
      mn_start   <= 1'b0;
      res_valid  <= 1'b0;
      res_winner <= '0;
      res_index  <= '0;
      res_status <= ST_OK;
    end else begin
      mn_start <= 1'b0;
      case (state)
        S_LOAD: begin
          if (in_valid) begin
            case (cnt)
              2'd0:    x_init_1 <= word;
              2'd1:    x_init_2 <= word;
              2'd2:    x_init_3 <= word;
              default: x_init_4 <= word;
            endcase
            if (nan_in) nan_flag <= 1'b1;
            if (cnt == CNT_LAST) begin
              state <= S_ARM;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 2'd1;
            end
          end
        end
        // Operands were written on entry to ARM, so they are stable for a full
        // cycle before the registered start pulse goes out.
        S_ARM: begin
          state    <= S_START;
          mn_start <= 1'b1;
        end
        S_START: begin
          state <= S_WAIT;
          tcnt  <= '0;
        end
        S_WAIT: begin
          if (mn_done) begin
            state      <= S_RESULT;
            res_valid  <= 1'b1;
            res_winner <= mn_out;
            res_index  <= enc_index;
            res_status <= nan_flag ? ST_NAN : (enc_bad ? ST_BADHOT : ST_OK);
          end else if (tcnt == TO_LAST) begin
            state      <= S_RESULT;
            res_valid  <= 1'b1;
            res_winner <= '0;
            res_index  <= enc_index;
            res_status <= ST_TIMEOUT;
          end else begin
            tcnt <= tcnt + 16'd1;
          end
        end
        S_RESULT: begin
          if (res_ready) begin
            state     <= S_LOAD;
            res_valid <= 1'b0;
            cnt       <= '0;
            tcnt      <= '0;
            nan_flag  <= 1'b0;
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end
endmodule
